// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lane geometry and lane index constants
// for the intersection traffic model.
package traffic_pkg;
    localparam int NUM_LANES  = 8;
    localparam int LANE_DEPTH = 8;

    localparam int LANE_W1 = 7;
    localparam int LANE_W2 = 6;
    localparam int LANE_S1 = 5;
    localparam int LANE_S2 = 4;
    localparam int LANE_E1 = 3;
    localparam int LANE_E2 = 2;
    localparam int LANE_N1 = 1;
    localparam int LANE_N2 = 0;

    typedef logic [LANE_DEPTH-1:0] lane_t;
endpackage

// File: rtl/lane_queue.sv
// lane_queue: one lane bitmap; slot 0 is the stop line, MSB the tail.
// Exposes per-slot move mask so the top can follow the emergency car.
module lane_queue
    import traffic_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  lane_t loadVal,
    input  logic  tick,
    input  logic  green,
    input  logic  arrive,
    output lane_t slots,
    output lane_t moved,
    output logic  departs,
    output logic  tailFree,
    output logic  ovf
);
    lane_t afterDep;
    lane_t postTick;
    lane_t nextSlots;

    always_comb begin
        departs = tick && green && slots[0];
        afterDep = slots;
        afterDep[0] = slots[0] && !departs;
        moved = '0;
        // each car looks only at the slot ahead as it stood after departure
        for (int j = 1; j < LANE_DEPTH; j++) begin
            moved[j] = tick && slots[j] && !afterDep[j-1];
        end
        postTick = (afterDep & ~moved) | (moved >> 1);
        tailFree = !postTick[LANE_DEPTH-1];
        nextSlots = postTick;
        nextSlots[LANE_DEPTH-1] = postTick[LANE_DEPTH-1] || arrive;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            slots <= loadVal;
            ovf   <= 1'b0;
        end else begin
            slots <= nextSlots;
            if (arrive && !tailFree) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/lane_traffic_model.sv
// lane_traffic_model: closed-loop intersection stimulus model.
// Owns the lane bitmaps, movement tick and emergency vehicle tracking.
module lane_traffic_model
    import traffic_pkg::*;
#(
    parameter int STEP_CYCLES = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_LANES-1:0]            greenIn,
    input  logic [NUM_LANES-1:0]            arrive,
    input  logic                            emgReq,
    input  logic [2:0]                      emgLaneSel,
    input  logic                            loadEn,
    input  logic [NUM_LANES*LANE_DEPTH-1:0] loadLanes,
    output logic [NUM_LANES*LANE_DEPTH-1:0] lanes,
    output logic                            emgSignal,
    output logic [NUM_LANES-1:0]            emgLane,
    output logic [NUM_LANES-1:0]            overflow,
    output logic                            emgDrop
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CW-1:0]        cnt;
    logic                 tick;
    logic [2:0]           emgIdx;
    logic [2:0]           emgPtr;
    logic                 emgAccept;
    logic                 emgLeaves;
    logic                 emgMoves;
    logic [NUM_LANES-1:0] tailFree;
    logic [NUM_LANES-1:0] departs;
    logic [NUM_LANES-1:0] laneIns;
    lane_t                moved [NUM_LANES];

    assign tick = (cnt == CW'(STEP_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (loadEn || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        emgAccept = emgReq && !emgSignal && tailFree[emgLaneSel];
        emgLeaves = emgSignal && (emgPtr == 3'd0) && departs[emgIdx];
        emgMoves  = emgSignal && moved[emgIdx][emgPtr];
        // an accepted emergency car merges with a same-lane arrival
        laneIns = arrive;
        if (emgAccept) begin
            laneIns[emgLaneSel] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        lane_queue uLane (
            .clk      (clk),
            .rst      (rst),
            .load     (loadEn),
            .loadVal  (loadLanes[i*LANE_DEPTH +: LANE_DEPTH]),
            .tick     (tick),
            .green    (greenIn[i]),
            .arrive   (laneIns[i]),
            .slots    (lanes[i*LANE_DEPTH +: LANE_DEPTH]),
            .moved    (moved[i]),
            .departs  (departs[i]),
            .tailFree (tailFree[i]),
            .ovf      (overflow[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emgSignal <= 1'b0;
            emgLane   <= '0;
            emgIdx    <= '0;
            emgPtr    <= '0;
            emgDrop   <= 1'b0;
        end else if (loadEn) begin
            emgSignal <= 1'b0;
            emgLane   <= '0;
            emgIdx    <= '0;
            emgPtr    <= '0;
            emgDrop   <= 1'b0;
        end else begin
            emgDrop <= emgReq && !emgAccept;
            if (emgAccept) begin
                emgSignal <= 1'b1;
                emgLane   <= 8'd1 << emgLaneSel;
                emgIdx    <= emgLaneSel;
                emgPtr    <= 3'd7;
            end else if (emgLeaves) begin
                emgSignal <= 1'b0;
                emgLane   <= '0;
            end else if (emgMoves) begin
                emgPtr <= emgPtr - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_lane_traffic_model.sv
// tb_lane_traffic_model: directed and random scenarios checked against
// a slot-by-slot behavioural model of the intersection lanes.
module tb_lane_traffic_model;
    localparam int STEP = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  greenIn = '0;
    logic [7:0]  arrive = '0;
    logic        emgReq = 1'b0;
    logic [2:0]  emgLaneSel = '0;
    logic        loadEn = 1'b0;
    logic [63:0] loadLanes = '0;
    logic [63:0] lanes;
    logic        emgSignal;
    logic [7:0]  emgLane;
    logic [7:0]  overflow;
    logic        emgDrop;

    int checks = 0;
    int errors = 0;

    logic [7:0] mLane [8];
    logic [7:0] mOvf;
    logic       mEmgOn;
    logic       mDrop;
    int         mEmgIdx;
    int         mEmgPos;
    int         mCnt;

    lane_traffic_model #(.STEP_CYCLES(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .greenIn    (greenIn),
        .arrive     (arrive),
        .emgReq     (emgReq),
        .emgLaneSel (emgLaneSel),
        .loadEn     (loadEn),
        .loadLanes  (loadLanes),
        .lanes      (lanes),
        .emgSignal  (emgSignal),
        .emgLane    (emgLane),
        .overflow   (overflow),
        .emgDrop    (emgDrop)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mLane[i] = '0;
        mOvf = '0;
        mEmgOn = 1'b0;
        mDrop = 1'b0;
        mEmgIdx = 0;
        mEmgPos = 0;
        mCnt = 0;
    endtask

    task automatic model_update();
        logic tk, oldOn, ok;
        logic [7:0] pre, dep, post;
        int newPos;
        if (loadEn) begin
            for (int i = 0; i < 8; i++) mLane[i] = loadLanes[8*i +: 8];
            mOvf = '0;
            mEmgOn = 1'b0;
            mDrop = 1'b0;
            mCnt = 0;
            return;
        end
        tk = (mCnt == STEP - 1);
        mCnt = tk ? 0 : mCnt + 1;
        oldOn = mEmgOn;
        newPos = mEmgPos;
        for (int i = 0; i < 8; i++) begin
            pre = mLane[i];
            post = pre;
            if (tk) begin
                dep = pre;
                if (greenIn[i] && pre[0]) begin
                    dep[0] = 1'b0;
                    post[0] = 1'b0;
                    if (oldOn && mEmgIdx == i && mEmgPos == 0) mEmgOn = 1'b0;
                end
                for (int j = 1; j < 8; j++) begin
                    if (pre[j] && !dep[j-1]) begin
                        post[j] = 1'b0;
                        post[j-1] = 1'b1;
                        if (oldOn && mEmgIdx == i && mEmgPos == j) newPos = j - 1;
                    end
                end
            end
            mLane[i] = post;
        end
        mEmgPos = newPos;
        ok = emgReq && !oldOn && !mLane[emgLaneSel][7];
        mDrop = emgReq && !ok;
        for (int i = 0; i < 8; i++) begin
            if (arrive[i] || (ok && int'(emgLaneSel) == i)) begin
                if (!mLane[i][7]) mLane[i][7] = 1'b1;
                else if (arrive[i]) mOvf[i] = 1'b1;
            end
        end
        if (ok) begin
            mEmgOn = 1'b1;
            mEmgIdx = int'(emgLaneSel);
            mEmgPos = 7;
        end
    endtask

    function automatic logic [81:0] expVec();
        logic [63:0] f;
        logic [7:0] el;
        for (int i = 0; i < 8; i++) f[8*i +: 8] = mLane[i];
        el = mEmgOn ? (8'd1 << mEmgIdx) : 8'd0;
        return {f, mOvf, mEmgOn, el, mDrop};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic load(input logic [63:0] v);
        loadLanes = v;
        loadEn = 1'b1;
        step();
        loadEn = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({lanes, overflow, emgSignal, emgLane, emgDrop} !== expVec()) begin
            errors++;
            $display("FAIL reset_init got %h exp %h",
                {lanes, overflow, emgSignal, emgLane, emgDrop}, expVec());
        end
        rst = 1'b0;
        load({$urandom, $urandom});
        for (int c = 0; c < 25; c++) begin
            arrive = 8'($urandom) & 8'($urandom);
            greenIn = 8'($urandom);
            emgReq = (c == 3);
            emgLaneSel = 3'($urandom_range(7, 0));
            step();
        end
        arrive = '0;
        emgReq = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({lanes, overflow, emgSignal, emgLane, emgDrop} !== expVec()) begin
            errors++;
            $display("FAIL reset_mid got %h exp %h",
                {lanes, overflow, emgSignal, emgLane, emgDrop}, expVec());
        end
        #2;
        rst = 1'b0;
    endtask

    task automatic test_advance();
        greenIn = '0;
        load({8'b00110000, 56'h0});
        for (int c = 0; c < 80; c++) begin
            step();
            checks++;
            if ({lanes, overflow, emgSignal, emgLane, emgDrop} !== expVec()) begin
                errors++;
                $display("FAIL advance c=%0d got %h exp %h", c,
                    {lanes, overflow, emgSignal, emgLane, emgDrop}, expVec());
            end
        end
        checks++;
        if (lanes[63:56] !== 8'b00000011) begin
            errors++;
            $display("FAIL advance_hold got %b exp 00000011", lanes[63:56]);
        end
    endtask

    task automatic test_depart();
        load({8'b00000011, 56'h0});
        greenIn = 8'b10000000;
        for (int c = 0; c < 30; c++) begin
            step();
            checks++;
            if ({lanes, overflow, emgSignal, emgLane, emgDrop} !== expVec()) begin
                errors++;
                $display("FAIL depart c=%0d got %h exp %h", c,
                    {lanes, overflow, emgSignal, emgLane, emgDrop}, expVec());
            end
        end
        greenIn = '0;
        checks++;
        if (lanes[63:56] !== 8'h00) begin
            errors++;
            $display("FAIL depart_empty got %b exp 00000000", lanes[63:56]);
        end
    endtask

    task automatic test_overflow();
        load(64'hFF << 32);
        arrive = 8'b00010000;
        step();
        arrive = '0;
        checks++;
        if (overflow !== 8'b00010000 || lanes !== (64'hFF << 32)) begin
            errors++;
            $display("FAIL overflow_set got ovf=%b lanes=%h exp ovf=00010000",
                overflow, lanes);
        end
        repeat (12) step();
        checks++;
        if ({lanes, overflow, emgSignal, emgLane, emgDrop} !== expVec()
            || overflow[4] !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got ovf=%b exp ovf=%b", overflow, mOvf);
        end
        load(64'h0);
        checks++;
        if (overflow !== 8'h00) begin
            errors++;
            $display("FAIL overflow_clear got %b exp 00000000", overflow);
        end
    endtask

    task automatic test_emergency();
        int c;
        greenIn = '0;
        load(64'h0);
        emgReq = 1'b1;
        emgLaneSel = 3'd2;
        step();
        emgReq = 1'b0;
        checks++;
        if (emgSignal !== 1'b1 || emgLane !== 8'b00000100 || lanes[23:16] !== 8'h80) begin
            errors++;
            $display("FAIL emg_inject got sig=%b lane=%b exp sig=1 lane=00000100",
                emgSignal, emgLane);
        end
        emgReq = 1'b1;
        emgLaneSel = 3'd5;
        step();
        emgReq = 1'b0;
        checks++;
        if (emgDrop !== 1'b1 || lanes[47:40] !== 8'h00) begin
            errors++;
            $display("FAIL emg_drop got %b exp 1", emgDrop);
        end
        step();
        checks++;
        if (emgDrop !== 1'b0 || emgLane !== 8'b00000100) begin
            errors++;
            $display("FAIL emg_drop_pulse got %b exp 0", emgDrop);
        end
        greenIn = 8'b00000100;
        c = 0;
        while (c < 200 && mEmgOn) begin
            step();
            c++;
            checks++;
            if ({lanes, overflow, emgSignal, emgLane, emgDrop} !== expVec()) begin
                errors++;
                $display("FAIL emg_track c=%0d got %h exp %h", c,
                    {lanes, overflow, emgSignal, emgLane, emgDrop}, expVec());
            end
        end
        greenIn = '0;
        checks++;
        if (mEmgOn || emgSignal !== 1'b0 || emgLane !== 8'h00 || lanes[23:16] !== 8'h00) begin
            errors++;
            $display("FAIL emg_leave got sig=%b lane=%b exp sig=0 lane=0 in %0d cycles",
                emgSignal, emgLane, c);
        end
    endtask

    task automatic test_tick_arrival();
        int c;
        greenIn = '0;
        load(64'h80);
        c = 0;
        while (mCnt != STEP - 1 && c < 2 * STEP) begin
            step();
            c++;
        end
        arrive = 8'b00000001;
        step();
        arrive = '0;
        checks++;
        if (lanes[7:0] !== 8'hC0 || overflow[0] !== 1'b0) begin
            errors++;
            $display("FAIL tick_arrival got lane=%b ovf=%b exp lane=11000000 ovf=0",
                lanes[7:0], overflow[0]);
        end
    endtask

    task automatic test_random();
        load({$urandom, $urandom});
        for (int c = 0; c < 600; c++) begin
            greenIn = 8'($urandom);
            arrive = 8'($urandom) & 8'($urandom) & 8'($urandom);
            emgReq = ($urandom_range(7, 0) == 0);
            emgLaneSel = 3'($urandom_range(7, 0));
            loadEn = ($urandom_range(59, 0) == 0);
            loadLanes = {$urandom, $urandom};
            step();
            loadEn = 1'b0;
            checks++;
            if ({lanes, overflow, emgSignal, emgLane, emgDrop} !== expVec()) begin
                errors++;
                $display("FAIL random c=%0d got %h exp %h", c,
                    {lanes, overflow, emgSignal, emgLane, emgDrop}, expVec());
            end
        end
        greenIn = '0;
        arrive = '0;
        emgReq = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        test_advance();
        test_depart();
        test_overflow();
        test_emergency();
        test_tick_arrival();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
